// File: rtl/shift_reg_univ_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// shift directions.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/shift_reg_univ_word_cnt.sv
// Counts consecutive same-direction shifts and raises a registered one-cycle
// word_valid_o strobe when WIDTH of them have been assembled.
module shift_word_cnt
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_i,
  input  logic                     dir_i,
  input  logic                     clear_i,
  output logic [$clog2(WIDTH)-1:0] bit_cnt_o,
  output logic                     word_valid_o
);

  localparam int CNT_W = $clog2(WIDTH);
  // One extra bit so n can hold WIDTH itself even for power-of-two widths.
  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dir_q, last_dir_d;
  logic             word_valid_q, word_valid_d;
  logic [CNT_W:0]   n;

  always_comb begin
    n = (dir_i == last_dir_q) ? ({1'b0, cnt_q} + (CNT_W+1)'(1))
                              : (CNT_W+1)'(1);
  end

  always_comb begin
    cnt_d        = cnt_q;
    last_dir_d   = last_dir_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      last_dir_d = dir_i;
      if (n == FULL) begin
        cnt_d        = '0;
        word_valid_d = 1'b1;
      end else begin
        cnt_d = n[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      last_dir_q   <= DIR_R;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_dir_q   <= last_dir_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bit_cnt_o    = cnt_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right/left with serial inputs, parallel
// load, plus a word-complete strobe from the shift counter.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     sin_r,
  input  logic                     sin_l,
  input  logic [WIDTH-1:0]         pdata,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  // Strobe, not a handshake: word_valid is high for exactly one cycle while q
  // holds a freshly completed word; there is no ready and no backpressure.
  output logic                     word_valid
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             shift_s, clear_s, dir_s;

  assign shift_s = en && is_shift(mode);
  assign clear_s = en && (mode == MODE_LOAD);
  assign dir_s   = (mode == MODE_SHL) ? DIR_L : DIR_R;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q_q;
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_LOAD: q_d = pdata;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RESET_VAL;
    else      q_q <= q_d;
  end

  shift_word_cnt #(.WIDTH(WIDTH)) u_word_cnt (
    .clk          (clk),
    .rst          (rst),
    .shift_i      (shift_s),
    .dir_i        (dir_s),
    .clear_i      (clear_s),
    .bit_cnt_o    (bit_cnt),
    .word_valid_o (word_valid)
  );

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a WIDTH=4 instance for the main sequences
// and a WIDTH=8, RESET_VAL=A5 instance for the wide-word case.
module tb_shift_reg_univ;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       en4 = 1'b0, sin_r4 = 1'b0, sin_l4 = 1'b0;
  logic [1:0] mode4 = 2'b00;
  logic [3:0] pdata4 = '0;
  logic [3:0] q4;
  logic       sout_r4, sout_l4, wv4;
  logic [1:0] cnt4;

  logic       en8 = 1'b0, sin_r8 = 1'b0, sin_l8 = 1'b0;
  logic [1:0] mode8 = 2'b00;
  logic [7:0] pdata8 = '0;
  logic [7:0] q8;
  logic       sout_r8, sout_l8, wv8;
  logic [2:0] cnt8;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .sin_r(sin_r4), .sin_l(sin_l4),
    .pdata(pdata4), .q(q4), .sout_r(sout_r4), .sout_l(sout_l4),
    .bit_cnt(cnt4), .word_valid(wv4)
  );

  shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .sin_r(sin_r8), .sin_l(sin_l8),
    .pdata(pdata8), .q(q8), .sout_r(sout_r8), .sout_l(sout_l8),
    .bit_cnt(cnt8), .word_valid(wv8)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic e, input logic [1:0] m, input logic sr,
                        input logic sl, input logic [3:0] pd);
    en4 = e; mode4 = m; sin_r4 = sr; sin_l4 = sl; pdata4 = pd;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk4(input string tag, input logic [3:0] eq, input logic [1:0] ec,
                      input logic ewv);
    chk({tag, ".q"},   32'(q4),   32'(eq));
    chk({tag, ".cnt"}, 32'(cnt4), 32'(ec));
    chk({tag, ".wv"},  32'(wv4),  32'(ewv));
  endtask

  task automatic chk8(input string tag, input logic [7:0] eq, input logic [2:0] ec,
                      input logic ewv);
    chk({tag, ".q"},   32'(q8),   32'(eq));
    chk({tag, ".cnt"}, 32'(cnt8), 32'(ec));
    chk({tag, ".wv"},  32'(wv8),  32'(ewv));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    tick(); tick();
    chk4("rst4", 4'b0000, 2'd0, 1'b0);
    chk8("rst8", 8'hA5, 3'd0, 1'b0);
    rst = 1'b1;

    // 1: SHR 1,1,0,1 from 0000
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t1s1", 4'b1000, 2'd1, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t1s2", 4'b1100, 2'd2, 1'b0);
    drive4(1, 2'b01, 0, 0, 4'h0); tick(); chk4("t1s3", 4'b0110, 2'd3, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t1s4", 4'b1011, 2'd0, 1'b1);

    // 2: SHR 0,1,1,0 back-to-back, second word 4 cycles after the first
    drive4(1, 2'b01, 0, 0, 4'h0); tick(); chk4("t2s1", 4'b0101, 2'd1, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t2s2", 4'b1010, 2'd2, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t2s3", 4'b1101, 2'd3, 1'b0);
    drive4(1, 2'b01, 0, 0, 4'h0); tick(); chk4("t2s4", 4'b0110, 2'd0, 1'b1);
    // asynchronous reset between edges
    #2 rst = 1'b0;
    #1 chk4("t2rst", 4'b0000, 2'd0, 1'b0);
    chk8("t2rst8", 8'hA5, 3'd0, 1'b0);
    #1 rst = 1'b1;

    // 3: LOAD 1010, then four SHR with sin_r=0; watch sout_r
    drive4(1, 2'b11, 0, 0, 4'b1010); tick(); chk4("t3ld", 4'b1010, 2'd0, 1'b0);
    chk("t3so0", 32'(sout_r4), 32'd0);
    drive4(1, 2'b01, 0, 0, 4'h0); tick(); chk("t3so1", 32'(sout_r4), 32'd1);
    chk4("t3s1", 4'b0101, 2'd1, 1'b0);
    tick(); chk("t3so2", 32'(sout_r4), 32'd0);
    tick(); chk("t3so3", 32'(sout_r4), 32'd1);
    chk4("t3s3", 4'b0001, 2'd3, 1'b0);
    tick(); chk4("t3s4", 4'b0000, 2'd0, 1'b1);

    // 4: two SHR, then SHL restarts the count
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t4r1", 4'b1000, 2'd1, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t4r2", 4'b1100, 2'd2, 1'b0);
    drive4(1, 2'b10, 0, 1, 4'h0); tick(); chk4("t4l1", 4'b1001, 2'd1, 1'b0);
    drive4(1, 2'b10, 0, 0, 4'h0); tick(); chk4("t4l2", 4'b0010, 2'd2, 1'b0);
    drive4(1, 2'b10, 0, 1, 4'h0); tick(); chk4("t4l3", 4'b0101, 2'd3, 1'b0);
    drive4(1, 2'b10, 0, 1, 4'h0); tick(); chk4("t4l4", 4'b1011, 2'd0, 1'b1);
    chk("t4sol", 32'(sout_l4), 32'd1);

    // 5: en=0 for three cycles in the middle of an SHR word
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t5s1", 4'b1101, 2'd1, 1'b0);
    drive4(1, 2'b01, 0, 0, 4'h0); tick(); chk4("t5s2", 4'b0110, 2'd2, 1'b0);
    drive4(0, 2'b01, 1, 1, 4'hF); tick(); chk4("t5f1", 4'b0110, 2'd2, 1'b0);
    tick(); chk4("t5f2", 4'b0110, 2'd2, 1'b0);
    tick(); chk4("t5f3", 4'b0110, 2'd2, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t5s3", 4'b1011, 2'd3, 1'b0);
    drive4(1, 2'b01, 1, 0, 4'h0); tick(); chk4("t5s4", 4'b1101, 2'd0, 1'b1);
    // strobe never stretches
    drive4(1, 2'b00, 1, 1, 4'h0); tick(); chk4("t5hold", 4'b1101, 2'd0, 1'b0);

    // 6: WIDTH=8, eight SHL of 1 from A5
    en8 = 1'b1; mode8 = 2'b10; sin_l8 = 1'b1;
    tick(); chk8("t6s1", 8'h4B, 3'd1, 1'b0);
    tick(); chk8("t6s2", 8'h97, 3'd2, 1'b0);
    tick(); chk8("t6s3", 8'h2F, 3'd3, 1'b0);
    tick(); chk8("t6s4", 8'h5F, 3'd4, 1'b0);
    tick(); chk8("t6s5", 8'hBF, 3'd5, 1'b0);
    tick(); chk8("t6s6", 8'h7F, 3'd6, 1'b0);
    tick(); chk8("t6s7", 8'hFF, 3'd7, 1'b0);
    tick(); chk8("t6s8", 8'hFF, 3'd0, 1'b1);
    mode8 = 2'b00;
    tick(); chk8("t6hold", 8'hFF, 3'd0, 1'b0);
    // six shifts, then a LOAD where the seventh would be
    mode8 = 2'b10;
    for (int i = 0; i < 6; i++) tick();
    chk8("t6b6", 8'hFF, 3'd6, 1'b0);
    mode8 = 2'b11; pdata8 = 8'h3C;
    tick(); chk8("t6ld", 8'h3C, 3'd0, 1'b0);
    mode8 = 2'b10; sin_l8 = 1'b0;
    tick(); chk8("t6after", 8'h78, 3'd1, 1'b0);
    en8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
Parametrised universal shift register. Successor to the fixed 4-bit SIPO: configurable width, bidirectional serial shift, parallel load and hold. Adds a shift counter that emits a one-cycle word-complete strobe after WIDTH consecutive same-direction shifts. Sits between bit-serial links and word-wide datapath logic; acts as SIPO, PISO, or bidirectional shifter depending on mode.

Parameters:
WIDTH, 4, register width in bits; legal range is 2 and above.
RESET_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset; rst=0 resets immediately
en  input  1  clock enable; when 0, all state holds
mode  input  2  operation select (encoding in package)
sin_r  input  1  serial input into MSB, used by SHR
sin_l  input  1  serial input into LSB, used by SHL
pdata  input  WIDTH  parallel load data
q  output  WIDTH  register contents
sout_r  output  1  q[0], the bit leaving on SHR
sout_l  output  1  q[WIDTH-1], the bit leaving on SHL
bit_cnt  output  CNT_W  same-direction shifts since last restart, modulo WIDTH
word_valid  output  1  one-cycle strobe: a full word has been assembled

Behaviour:
- Reset (rst=0, asynchronous):
  - q=RESET_VAL, bit_cnt=0, word_valid=0, last_dir=SHR.
  - Reset asserted mid-operation aborts any partial word; no word_valid is produced for it.
- Reset release: first active edge is the first clk rising edge with rst=1.
- en=0: q, bit_cnt and last_dir hold. word_valid is forced to 0, so the strobe never stretches.
- en=1, per rising edge, by mode:
  - HOLD (00): q holds; bit_cnt holds; word_valid=0.
  - SHR (01): q <= {sin_r, q[WIDTH-1:1]}.
  - SHL (10): q <= {q[WIDTH-2:0], sin_l}.
  - LOAD (11): q <= pdata; bit_cnt <= 0; word_valid=0; last_dir unchanged.
- Shift counting (SHR/SHL only):
  - If the shift direction equals last_dir, define n = bit_cnt+1; otherwise n = 1 (direction change restarts the word and the current shift is bit 1).
  - last_dir <= current direction.
  - If n == WIDTH: bit_cnt <= 0 and word_valid <= 1. Otherwise bit_cnt <= n and word_valid <= 0.
- word_valid is registered. It is high during the cycle after the completing edge, coincident with q holding the complete word. It is always exactly one cycle wide.
- Back-to-back words: continuous same-direction shifting pulses word_valid every WIDTH cycles with no gap cycle.
- Outputs: sout_r and sout_l are combinational taps of q. Shift-out bit order is LSB-first for SHR and MSB-first for SHL.
- Widths: CNT_W = $clog2(WIDTH). When WIDTH is a power of two, bit_cnt never reaches WIDTH; the wrap is explicit, not overflow-dependent.

Decomposition:
- Package shift_pkg contains:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - direction constants DIR_R=1'b0, DIR_L=1'b1.
- One natural sub-module, shift_word_cnt. It holds the counter, last_dir and word_valid logic. Inputs: shift strobe, direction, clear. Parameter: WIDTH.
- Datapath mux and register stay in shift_reg_univ.

Test Plan:
1. WIDTH=4, reset, then SHR with sin_r = 1,1,0,1 on four edges -> q steps 1000, 1100, 0110, 1011; word_valid=1 for exactly the cycle q=1011; bit_cnt 1, 2, 3, 0.
2. Continue SHR with sin_r = 0,1,1,0 -> q=0110 with a second word_valid exactly 4 cycles after the first; then rst=0 mid-clock -> q=0000, bit_cnt=0 immediately, without waiting for a clock edge.
3. LOAD pdata=1010, then 4×SHR with sin_r=0 -> sout_r sequence 0,1,0,1; q=0000; word_valid on the 4th shift.
4. Two SHR shifts, then SHL -> bit_cnt=1 after the SHL (restart). Three more SHL -> word_valid, q consistent with LSB-insertion.
5. en=0 for 3 cycles between shift 2 and shift 3 of a word, with mode=SHR -> q and bit_cnt frozen; word_valid occurs only after the 4th enabled shift.
6. WIDTH=8, RESET_VAL=8'hA5: after reset q=A5. Eight SHL shifts of sin_l=1 -> q=FF and a single word_valid pulse; a LOAD issued on shift 7 instead -> no word_valid and bit_cnt=0.
